// File: rtl/eh2_pkg.sv
// Shared types for the eh2 retire-trace capture path.
// Entry layout and packing helper.
package eh2_pkg;

  localparam int EH2_TRACE_ENTRY_W = 102;

  typedef struct packed {
    logic [30:0] pc;
    logic [31:0] insn;
    logic        exc;
    logic        intr;
    logic [4:0]  ecause;
    logic [31:0] tval;
  } eh2_trace_entry_t;

  // Cause and tval only mean something on a trapping retirement.
  function automatic eh2_trace_entry_t eh2_trace_pack(
    input logic [30:0] pc,
    input logic [31:0] insn,
    input logic        exc,
    input logic        intr,
    input logic [4:0]  ecause,
    input logic [31:0] tval
  );
    eh2_trace_entry_t e;
    logic             trap;
    trap     = exc | intr;
    e.pc     = pc;
    e.insn   = insn;
    e.exc    = exc;
    e.intr   = intr;
    e.ecause = trap ? ecause : 5'd0;
    e.tval   = trap ? tval : 32'd0;
    return e;
  endfunction

endpackage

// File: rtl/eh2_trace_fifo2w1r.sv
// Two-write, one-read FWFT FIFO for retire trace entries.
// Storage is not reset; pointers and count are.
module eh2_trace_fifo2w1r #(
  parameter int DEPTH = 16,
  parameter int W     = 102
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     i_clr,
  input  logic [1:0]               i_wr_n,
  input  logic [W-1:0]             i_wd0,
  input  logic [W-1:0]             i_wd1,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW-1:0] w_wr_ptr1;

  assign w_wr_ptr1 = r_wr_ptr + AW'(1);

  // Write accepted entries in order, slot A then slot B.
  always_ff @(posedge clk) begin
    if (!i_clr) begin
      if (i_wr_n != 2'd0) r_mem[r_wr_ptr] <= i_wd0;
      if (i_wr_n == 2'd2) r_mem[w_wr_ptr1] <= i_wd1;
    end
  end

  // Pointer and occupancy bookkeeping; clear wins over push/pop.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(i_wr_n);
      r_rd_ptr <= r_rd_ptr + AW'(i_pop);
      r_count  <= r_count + (AW+1)'(i_wr_n)
                - (AW+1)'(i_pop);
    end
  end

  assign o_count   = r_count;
  assign o_rd_data = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/eh2_trace_capture_buf.sv
// Captures eh2 thread-0 retire trace into an in-order FIFO.
// All-or-nothing per cycle, with sticky overflow and drop count.
module eh2_trace_capture_buf
  import eh2_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic                         trace_en,
  input  logic                         trace_clr,
  input  logic [1:0]                   trace_rv_i_valid_ip,
  input  logic [63:0]                  trace_rv_i_insn_ip,
  input  logic [63:0]                  trace_rv_i_address_ip,
  input  logic [1:0]                   trace_rv_i_exception_ip,
  input  logic [1:0]                   trace_rv_i_interrupt_ip,
  input  logic [4:0]                   trace_rv_i_ecause_ip,
  input  logic [31:0]                  trace_rv_i_tval_ip,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [EH2_TRACE_ENTRY_W-1:0] rd_data,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow,
  output logic [CNT_W-1:0]             drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]       w_v;
  logic [1:0]       w_n;
  logic [1:0]       w_acc_n;
  logic             w_pop;
  logic             w_fit;
  logic [CW:0]      w_space;
  logic [CNT_W:0]   w_drop_sum;
  eh2_trace_entry_t w_e0;
  eh2_trace_entry_t w_e1;
  eh2_trace_entry_t w_d0;
  logic             w_unused_pc;

  logic             r_overflow;
  logic [CNT_W-1:0] r_drop_cnt;

  assign w_unused_pc = trace_rv_i_address_ip[0]
                     ^ trace_rv_i_address_ip[32];

  assign w_v = trace_rv_i_valid_ip & {2{trace_en}};
  assign w_n = {1'b0, w_v[0]} + {1'b0, w_v[1]};

  assign w_e0 = eh2_trace_pack(
    trace_rv_i_address_ip[31:1],
    trace_rv_i_insn_ip[31:0],
    trace_rv_i_exception_ip[0],
    trace_rv_i_interrupt_ip[0],
    trace_rv_i_ecause_ip,
    trace_rv_i_tval_ip);

  assign w_e1 = eh2_trace_pack(
    trace_rv_i_address_ip[63:33],
    trace_rv_i_insn_ip[63:32],
    trace_rv_i_exception_ip[1],
    trace_rv_i_interrupt_ip[1],
    trace_rv_i_ecause_ip,
    trace_rv_i_tval_ip);

  // A lone slot1 retirement takes the first write port.
  assign w_d0 = w_v[0] ? w_e0 : w_e1;

  assign rd_valid = (count != '0);
  assign w_pop    = rd_valid & rd_ready;

  assign w_space = (CW+1)'(DEPTH) - {1'b0, count}
                 + {{CW{1'b0}}, w_pop};
  assign w_fit   = ((CW+1)'(w_n) <= w_space);
  assign w_acc_n = w_fit ? w_n : 2'd0;

  assign w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_n);

  eh2_trace_fifo2w1r #(
    .DEPTH (DEPTH),
    .W     (EH2_TRACE_ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_l     (rst_l),
    .i_clr     (trace_clr),
    .i_wr_n    (w_acc_n),
    .i_wd0     (w_d0),
    .i_wd1     (w_e1),
    .i_pop     (w_pop),
    .o_rd_data (rd_data),
    .o_count   (count)
  );

  // Sticky overflow and saturating drop counter.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (trace_clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (!w_fit) begin
      r_overflow <= 1'b1;
      r_drop_cnt <= w_drop_sum[CNT_W] ? '1
                  : w_drop_sum[CNT_W-1:0];
    end
  end

  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule
